bit_serial_alu: RTL

BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_slice.sv | 37 +++
 rtl/bit_serial_alu.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: control codes, slice operations,
// FSM encoding and the helpers that derive counter width and slice controls.
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic       invert_a;
        logic       invert_b;
        logic [1:0] op;
        logic       valid;
    } slice_ctrl_t;

    // Bit counter must index 0..width-1; never let it collapse to zero bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic slice_ctrl_t decode_ctrl(input logic [3:0] ctrl);
        slice_ctrl_t s;
        s = '{invert_a: 1'b0, invert_b: 1'b0, op: OP_AND, valid: 1'b0};
        case (ctrl)
            CTRL_AND: s = '{invert_a: 1'b0, invert_b: 1'b0, op: OP_AND, valid: 1'b1};
            CTRL_OR:  s = '{invert_a: 1'b0, invert_b: 1'b0, op: OP_OR,  valid: 1'b1};
            CTRL_ADD: s = '{invert_a: 1'b0, invert_b: 1'b0, op: OP_ADD, valid: 1'b1};
            CTRL_SUB: s = '{invert_a: 1'b0, invert_b: 1'b1, op: OP_ADD, valid: 1'b1};
            CTRL_SLT: s = '{invert_a: 1'b0, invert_b: 1'b1, op: OP_ADD, valid: 1'b1};
            CTRL_NOR: s = '{invert_a: 1'b1, invert_b: 1'b1, op: OP_AND, valid: 1'b1};
            default:  ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: optional operand inversion, then AND / OR / full-add /
// pass-through of the less input.
module alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       invert_a,
    input  logic       invert_b,
    input  logic [1:0] op,
    input  logic       carry_in,
    input  logic       less,
    output logic       result,
    output logic       carry_out
);

    logic ai;
    logic bi;
    logic sum;

    assign ai        = a ^ invert_a;
    assign bi        = b ^ invert_b;
    assign sum       = ai ^ bi ^ carry_in;
    assign carry_out = (ai & bi) | (ai & carry_in) | (bi & carry_in);

    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = ai & bi;
            OP_OR:   result = ai | bi;
            OP_ADD:  result = sum;
            OP_LESS: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: operands shift LSB-first through a single alu_slice, one bit
// per cycle, and the assembled result is published when the FIN state retires.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;

    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_sr_q;
    logic [3:0]       ctrl_q;
    slice_ctrl_t      sctl_q;
    slice_ctrl_t      start_ctl;
    logic             cin_msb_q;
    logic             cout_msb_q;
    logic             sum_msb_q;

    logic             start_acc;
    logic             last_bit;
    logic             ovf_msb;

    logic             sl_inv_a;
    logic             sl_inv_b;
    logic [1:0]       sl_op;
    logic             sl_cin;
    logic             sl_less;
    logic             sl_res;
    logic             sl_cout;

    logic [WIDTH-1:0] fin_result;
    logic             fin_cout;
    logic             fin_ovf;

    assign start_ctl = decode_ctrl(ctrl_i);
    assign last_bit  = (cnt_q == LAST_BIT);
    assign ovf_msb   = cin_msb_q ^ cout_msb_q;
    assign busy_o    = (state_q != ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    start_acc = 1'b1;
                end
            end
            ST_RUN:  if (last_bit) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // In FIN the slice is reused in less-mode to produce the SLT bit.
    always_comb begin
        sl_inv_a = sctl_q.invert_a;
        sl_inv_b = sctl_q.invert_b;
        sl_op    = sctl_q.op;
        sl_cin   = carry_q;
        sl_less  = 1'b0;
        if (state_q == ST_FIN) begin
            sl_op   = OP_LESS;
            sl_less = sum_msb_q ^ ovf_msb;
        end
    end

    alu_slice u_slice (
        .a         (a_sr_q[0]),
        .b         (b_sr_q[0]),
        .invert_a  (sl_inv_a),
        .invert_b  (sl_inv_b),
        .op        (sl_op),
        .carry_in  (sl_cin),
        .less      (sl_less),
        .result    (sl_res),
        .carry_out (sl_cout)
    );

    always_comb begin
        fin_result = '0;
        fin_cout   = 1'b0;
        fin_ovf    = 1'b0;
        if (sctl_q.valid) begin
            case (ctrl_q)
                CTRL_SLT: begin
                    fin_result[0] = sl_res;
                    fin_cout      = cout_msb_q;
                end
                CTRL_ADD, CTRL_SUB: begin
                    fin_result = res_sr_q;
                    fin_cout   = cout_msb_q;
                    fin_ovf    = ovf_msb;
                end
                default: fin_result = res_sr_q;
            endcase
        end
    end

    // Control and architecturally visible outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        cnt_q   <= '0;
                        carry_q <= start_ctl.invert_b;
                    end
                end
                ST_RUN: begin
                    cnt_q   <= cnt_q + 1'b1;
                    carry_q <= sl_cout;
                end
                ST_FIN: begin
                    result_o   <= fin_result;
                    zero_o     <= (fin_result == '0);
                    cout_o     <= fin_cout;
                    overflow_o <= fin_ovf;
                    done_o     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand and result shift registers carry no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_IDLE && start_acc) begin
            a_sr_q <= src1_i;
            b_sr_q <= src2_i;
            ctrl_q <= ctrl_i;
            sctl_q <= start_ctl;
        end else if (state_q == ST_RUN) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= (res_sr_q >> 1) | (WIDTH'(sl_res) << (WIDTH - 1));
            if (last_bit) begin
                cin_msb_q  <= carry_q;
                cout_msb_q <= sl_cout;
                sum_msb_q  <= sl_res;
            end
        end
    end

endmodule
